mmio_uart_tx: RTL and testbench

//  MMIO responder on the memory crossbar's MMIO port: word-addressed register file fronting a TX FIFO
//  and an 8N1 UART transmitter. CPU stores push bytes into the FIFO; the serializer drains them onto o_tx.

---
 rtl/mmio_uart_tx.sv | 136 +++++++++++++
 tb/tb_mmio_uart_tx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - MMIO register file fronting a TX FIFO and an 8N1 UART serializer
module mmio_uart_tx #(
  parameter int FIFO_DEPTH   = 16,
  parameter int BAUD_DIV_RST = 434
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [29:0] i_addr,
  input  logic [31:0] i_data,
  input  logic        i_wren,
  input  logic [3:0]  i_mask,
  output logic [31:0] o_data,
  output logic        o_tx,
  output logic        o_irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e        state_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q;
  logic [15:0]   baud_q, period_q, period_d, cnt_q;
  logic [7:0]    shift_q;
  logic [2:0]    bit_q;
  logic          tx_q, irq_q;
  logic          full, empty, busy, push, push_ok, pop, bit_end, idle_d;
  logic          unused_bits;

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign busy     = (state_q != S_IDLE);
  assign push     = i_wren && (i_addr == 30'd0) && i_mask[0];
  assign push_ok  = push && !full;
  assign pop      = (state_q == S_IDLE) && !empty;
  assign count_d  = count_q + CW'(push_ok) - CW'(pop);
  assign period_d = (baud_q == 16'd0) ? 16'd1 : baud_q;
  assign bit_end  = (cnt_q == period_q - 16'd1);
  assign idle_d   = (state_q == S_IDLE) ? !pop : ((state_q == S_STOP) && bit_end);
  assign unused_bits = ^{i_data[31:16], i_mask[3:2]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      baud_q   <= 16'(BAUD_DIV_RST);
      irq_q    <= 1'b1;
    end else begin
      count_q <= count_d;
      irq_q   <= (count_d == '0) && idle_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      // A push into a full FIFO is dropped even if the serializer pops on the same edge
      if (push && full) ovf_q <= 1'b1;
      else if (i_wren && (i_addr == 30'd1) && i_mask[0] && i_data[3]) ovf_q <= 1'b0;
      if (i_wren && (i_addr == 30'd2)) begin
        if (i_mask[0]) baud_q[7:0]  <= i_data[7:0];
        if (i_mask[1]) baud_q[15:8] <= i_data[15:8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_data[7:0];
  end

  // tx_q is loaded with the level of the state being entered, so the line changes on the transition edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      tx_q     <= 1'b1;
      cnt_q    <= '0;
      period_q <= 16'd1;
      shift_q  <= '0;
      bit_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_q  <= S_START;
            tx_q     <= 1'b0;
            shift_q  <= mem_q[rd_ptr_q];
            cnt_q    <= '0;
            period_q <= period_d;
          end
        end
        default: begin
          if (bit_end) begin
            cnt_q    <= '0;
            period_q <= period_d;
            case (state_q)
              S_START: begin
                state_q <= S_DATA;
                bit_q   <= '0;
                tx_q    <= shift_q[0];
              end
              S_DATA: begin
                if (bit_q == 3'd7) begin
                  state_q <= S_STOP;
                  tx_q    <= 1'b1;
                end else begin
                  shift_q <= shift_q >> 1;
                  bit_q   <= bit_q + 3'd1;
                  tx_q    <= shift_q[1];
                end
              end
              default: begin
                state_q <= S_IDLE;
                tx_q    <= 1'b1;
              end
            endcase
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
      endcase
    end
  end

  always_comb begin
    o_data = '0;
    case (i_addr)
      30'd1:   o_data = {16'd0, 8'(count_q), 4'd0, ovf_q, empty, full, busy};
      30'd2:   o_data = {16'd0, baud_q};
      default: o_data = '0;
    endcase
  end

  assign o_tx  = tx_q;
  assign o_irq = irq_q;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wren = 1'b0;
  logic [29:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  mask = '0;
  logic [31:0] rdata;
  logic        tx, irq;

  int total = 0;
  int bad = 0;
  bit log_en = 1'b0;
  bit txlog[$];
  bit irqlog[$];
  logic [7:0] bq[$];

  typedef struct packed {
    logic        do_wr;
    logic [29:0] waddr;
    logic [31:0] wd;
    logic [3:0]  wm;
    logic [29:0] raddr;
    logic [31:0] exp;
  } vec_t;
  vec_t tv[$];

  mmio_uart_tx #(.FIFO_DEPTH(16), .BAUD_DIV_RST(434)) dut (
    .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_data(wdata), .i_wren(wren),
    .i_mask(mask), .o_data(rdata), .o_tx(tx), .o_irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (log_en) begin
      txlog.push_back(tx);
      irqlog.push_back(irq);
    end
  endtask

  task automatic wr(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
    addr = a; wdata = d; mask = m; wren = 1'b1;
    step();
    wren = 1'b0; mask = '0; addr = '0;
  endtask

  task automatic rd(input logic [29:0] a, output logic [31:0] v);
    wren = 1'b0; addr = a;
    #1;
    v = rdata;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Line model: one idle sample after the first push edge, then per byte start,
  // 8 data bits LSB first and stop, each max(div,1) cycles, then one idle cycle.
  task automatic run_burst(input string name, input int div);
    bit etx[$];
    bit eirq[$];
    int p, errs, first;
    logic [31:0] st;
    p = (div == 0) ? 1 : div;
    wr(30'd2, 32'(div), 4'b0011);
    etx.push_back(1'b1);
    eirq.push_back(1'b0);
    foreach (bq[k]) begin
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < p; c++) begin
          etx.push_back((b == 0) ? 1'b0 : (b == 9) ? 1'b1 : bq[k][b-1]);
          eirq.push_back(1'b0);
        end
      end
      etx.push_back(1'b1);
      eirq.push_back(k == bq.size() - 1);
    end
    for (int k = 0; k < 3; k++) begin
      etx.push_back(1'b1);
      eirq.push_back(1'b1);
    end
    txlog.delete();
    irqlog.delete();
    log_en = 1'b1;
    foreach (bq[k]) wr(30'd0, {24'h0, bq[k]}, 4'b0001);
    while (txlog.size() < etx.size()) step();
    log_en = 1'b0;
    errs = 0; first = -1;
    foreach (etx[i]) if (txlog[i] != etx[i]) begin errs++; if (first < 0) first = i; end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL %s_tx: %0d samples differ, first at %0d got %0d want %0d",
               name, errs, first, txlog[first], etx[first]);
    end
    errs = 0; first = -1;
    foreach (eirq[i]) if (irqlog[i] != eirq[i]) begin errs++; if (first < 0) first = i; end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL %s_irq: %0d samples differ, first at %0d got %0d want %0d",
               name, errs, first, irqlog[first], eirq[first]);
    end
    rd(30'd1, st);
    chk({name, "_status"}, st, 32'h4);
  endtask

  initial begin
    logic [31:0] v;
    int lows;

    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_irq", {31'd0, irq}, 32'd1);

    tv.push_back('{1'b0, 30'd0,          32'h0,        4'h0, 30'd1,          32'h4});
    tv.push_back('{1'b0, 30'd0,          32'h0,        4'h0, 30'd2,          32'd434});
    tv.push_back('{1'b0, 30'd0,          32'h0,        4'h0, 30'd0,          32'h0});
    tv.push_back('{1'b0, 30'd0,          32'h0,        4'h0, 30'd7,          32'h0});
    tv.push_back('{1'b1, 30'd2,          32'h0000ABCD, 4'h1, 30'd2,          32'h01CD});
    tv.push_back('{1'b1, 30'd2,          32'h00001234, 4'h2, 30'd2,          32'h12CD});
    tv.push_back('{1'b1, 30'd2,          32'hFFFF0005, 4'hF, 30'd2,          32'h0005});
    tv.push_back('{1'b1, 30'd2,          32'h00009999, 4'h0, 30'd2,          32'h0005});
    tv.push_back('{1'b1, 30'd7,          32'h00000055, 4'hF, 30'd7,          32'h0});
    tv.push_back('{1'b1, 30'd3,          32'h00000001, 4'hF, 30'd2,          32'h0005});
    tv.push_back('{1'b1, 30'd0,          32'h00000055, 4'h2, 30'd1,          32'h4});
    tv.push_back('{1'b1, 30'd1,          32'h000000FF, 4'hF, 30'd1,          32'h4});
    tv.push_back('{1'b1, 30'h3FFFFFFF,   32'h00000077, 4'hF, 30'h3FFFFFFF,   32'h0});
    tv.push_back('{1'b1, 30'd2,          32'h00000000, 4'h3, 30'd2,          32'h0});
    foreach (tv[i]) begin
      if (tv[i].do_wr) wr(tv[i].waddr, tv[i].wd, tv[i].wm);
      rd(tv[i].raddr, v);
      chk($sformatf("vec%0d", i), v, tv[i].exp);
    end
    step();
    chk("masked_push_tx", {31'd0, tx}, 32'd1);
    chk("masked_push_irq", {31'd0, irq}, 32'd1);

    bq.delete(); bq.push_back(8'hA5);
    run_burst("a5_div4", 4);
    bq.delete(); bq.push_back(8'h00); bq.push_back(8'hFF); bq.push_back(8'h0F);
    run_burst("three_div2", 2);
    bq.delete(); bq.push_back(8'h3C); bq.push_back(8'hC3);
    run_burst("div0", 0);

    wr(30'd2, 32'd1000, 4'b0011);
    for (int i = 0; i < 17; i++) wr(30'd0, 32'(i + 8'h40), 4'b0001);
    rd(30'd1, v);
    chk("full_status", v, 32'h1003);
    wr(30'd0, 32'h99, 4'b0001);
    rd(30'd1, v);
    chk("ovf_status", v, 32'h100B);
    wr(30'd1, 32'h8, 4'b1110);
    rd(30'd1, v);
    chk("ovf_clear_masked", v, 32'h100B);
    wr(30'd1, 32'hF7, 4'b0001);
    rd(30'd1, v);
    chk("ovf_clear_bit3_0", v, 32'h100B);
    wr(30'd1, 32'h8, 4'b0001);
    rd(30'd1, v);
    chk("ovf_cleared", v, 32'h1003);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("flush_tx", {31'd0, tx}, 32'd1);
    rd(30'd1, v);
    chk("flush_status", v, 32'h4);
    rd(30'd2, v);
    chk("flush_baud", v, 32'd434);

    wr(30'd2, 32'd4, 4'b0011);
    wr(30'd0, 32'h00, 4'b0001);
    wr(30'd0, 32'h3C, 4'b0001);
    for (int i = 0; i < 17; i++) step();
    chk("data_bit3_tx", {31'd0, tx}, 32'd0);
    rd(30'd1, v);
    chk("data_bit3_status", v, 32'h101);
    rd(30'd7, v);
    chk("busy_addr7", v, 32'h0);
    rst = 1'b1;
    step();
    chk("midframe_rst_tx", {31'd0, tx}, 32'd1);
    chk("midframe_rst_irq", {31'd0, irq}, 32'd1);
    rd(30'd1, v);
    chk("midframe_rst_status", v, 32'h4);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (tx !== 1'b1) lows++;
    end
    chk("no_partial_frame", 32'(lows), 32'd0);

    for (int r = 0; r < 6; r++) begin
      int n, div;
      n = $urandom_range(1, 12);
      div = $urandom_range(1, 3);
      bq.delete();
      for (int k = 0; k < n; k++) bq.push_back(8'($urandom));
      run_burst($sformatf("rand%0d", r), div);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
